// File: rtl/shift_seq_pkg.sv
// Shared definitions for the sequential shifter: FSM state encoding, op codes and
// default geometry.
package shift_seq_pkg;

   localparam int SHIFT_WIDTH_DEF = 16;
   localparam int SHIFT_AMT_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SRL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

endpackage

// File: rtl/shift_seq_arb.sv
// Two-requester round-robin arbiter: on contention the requester not served last
// wins; a lone requester always wins.
module shift_seq_arb (
   input  logic [1:0] req,
   input  logic       enable,
   input  logic       last_id,
   output logic [1:0] grant
);

   // NOTE: grant gets a default before any branch so the block stays purely combinational
   // (no latch) whichever path is taken.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (req == 2'b11) grant = last_id ? 2'b01 : 2'b10;
         else              grant = req;
      end
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Two-requester bit-serial shifter (1 bit per cycle). Optional macro
// SHIFT_SEQ_ROTATE_EN enables ROR/ROL; otherwise op bit 1 is ignored.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = SHIFT_WIDTH_DEF,
   parameter int AMT_W = SHIFT_AMT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [1:0]       REQ,
   input  logic [1:0]       OP_0,
   input  logic [1:0]       OP_1,
   input  logic [WIDTH-1:0] DATA_0,
   input  logic [WIDTH-1:0] DATA_1,
   input  logic [AMT_W-1:0] AMT_0,
   input  logic [AMT_W-1:0] AMT_1,
   output logic             BUSY,
   output logic             DONE,
   output logic             DONE_ID,
   output logic [WIDTH-1:0] SHIFT_OUT,
   output logic             SHIFT_Flag
);

   state_t           state_q;
   logic [WIDTH-1:0] work_q, work_nxt;
   logic [AMT_W-1:0] count_q;
   logic [1:0]       op_q;
   logic             carry_q, carry_nxt;
   logic             cur_id_q;
   logic             last_id_q;
   logic             done_id_q;
   logic [WIDTH-1:0] shift_out_q;
   logic             flag_q;
   logic [1:0]       grant;

   shift_seq_arb u_arb (
      .req     (REQ),
      .enable  (state_q == ST_IDLE),
      .last_id (last_id_q),
      .grant   (grant)
   );

   // One-bit step of the working register; the exiting bit becomes the carry.
   always_comb begin
      work_nxt  = work_q;
      carry_nxt = carry_q;
      case (op_q)
`ifdef SHIFT_SEQ_ROTATE_EN
         OP_SRL: begin work_nxt = {1'b0, work_q[WIDTH-1:1]};           carry_nxt = work_q[0];       end
         OP_SLL: begin work_nxt = {work_q[WIDTH-2:0], 1'b0};           carry_nxt = work_q[WIDTH-1]; end
         OP_ROR: begin work_nxt = {work_q[0], work_q[WIDTH-1:1]};      carry_nxt = work_q[0];       end
         OP_ROL: begin work_nxt = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; carry_nxt = work_q[WIDTH-1]; end
`else
         OP_SRL, OP_ROR: begin work_nxt = {1'b0, work_q[WIDTH-1:1]}; carry_nxt = work_q[0];       end
         OP_SLL, OP_ROL: begin work_nxt = {work_q[WIDTH-2:0], 1'b0}; carry_nxt = work_q[WIDTH-1]; end
`endif
         default: ;
      endcase
   end

   // NOTE: all state below is written with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         work_q      <= '0;
         count_q     <= '0;
         op_q        <= OP_SRL;
         carry_q     <= 1'b0;
         cur_id_q    <= 1'b0;
         last_id_q   <= 1'b1;
         done_id_q   <= 1'b0;
         shift_out_q <= '0;
         flag_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|grant) begin
                  work_q    <= grant[1] ? DATA_1 : DATA_0;
                  count_q   <= grant[1] ? AMT_1  : AMT_0;
                  op_q      <= grant[1] ? OP_1   : OP_0;
                  carry_q   <= 1'b0;
                  cur_id_q  <= grant[1];
                  last_id_q <= grant[1];
                  state_q   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (count_q == '0) begin
                  shift_out_q <= work_q;
                  flag_q      <= carry_q;
                  done_id_q   <= cur_id_q;
                  state_q     <= ST_DONE;
               end else begin
                  work_q  <= work_nxt;
                  carry_q <= carry_nxt;
                  count_q <= count_q - AMT_W'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign BUSY       = (state_q != ST_IDLE);
   assign DONE       = (state_q == ST_DONE);
   assign DONE_ID    = done_id_q;
   assign SHIFT_OUT  = shift_out_q;
   assign SHIFT_Flag = flag_q;

endmodule
